// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, state
// encoding and datapath mux select values.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned WAIT_W   = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_AND   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_OR    = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_XOR   = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_NOT   = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_JZ    = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_JNZ   = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

    localparam logic AC_SRC_ALU = 1'b0;
    localparam logic AC_SRC_MEM = 1'b1;
    localparam logic PC_SRC_INC = 1'b0;
    localparam logic PC_SRC_JMP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode; every control is forced low outside EXECUTE so
// the datapath only ever sees strobes during the single execute cycle.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ac_zero,
    input  logic                in_execute,
    output logic                ld_ac,
    output logic                ac_src,
    output logic                pc_src,
    output logic                ld_pc,
    output logic                dm_we,
    output logic                is_halt,
    output logic                is_illegal
);

    always_comb begin
        ld_ac      = 1'b0;
        ac_src     = AC_SRC_ALU;
        pc_src     = PC_SRC_INC;
        ld_pc      = 1'b0;
        dm_we      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (in_execute) begin
            case (opcode)
                OP_NOP: begin
                    ld_pc = 1'b1;
                end
                OP_LOAD: begin
                    ld_ac  = 1'b1;
                    ac_src = AC_SRC_MEM;
                    ld_pc  = 1'b1;
                end
                OP_STORE: begin
                    dm_we = 1'b1;
                    ld_pc = 1'b1;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                    ld_ac  = 1'b1;
                    ac_src = AC_SRC_ALU;
                    ld_pc  = 1'b1;
                end
                OP_JMP: begin
                    pc_src = PC_SRC_JMP;
                    ld_pc  = 1'b1;
                end
                OP_JZ: begin
                    pc_src = ac_zero ? PC_SRC_JMP : PC_SRC_INC;
                    ld_pc  = 1'b1;
                end
                OP_JNZ: begin
                    pc_src = ac_zero ? PC_SRC_INC : PC_SRC_JMP;
                    ld_pc  = 1'b1;
                end
                OP_HALT: begin
                    is_halt = 1'b1;
                end
                // 0xC-0xE: advance like a NOP but flag the fault
                default: begin
                    ld_pc      = 1'b1;
                    is_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle fetch/execute sequencer for the accumulator CPU with single-step
// debug, terminal HALT, sticky illegal-opcode flag and retired-instruction count.
module control_unit_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 1,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                step_mode,
    input  logic                step,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   ac_in,
    output logic                ld_ac,
    output logic                ac_src,
    output logic                pc_src,
    output logic                ld_pc,
    output logic                dm_we,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [COUNT_W-1:0]  instr_count
);

    localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(FETCH_WAIT - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic [COUNT_W-1:0]  count_nxt;
    logic                illegal_nxt;
    logic                in_execute;
    logic                ac_zero;
    logic                is_halt;
    logic                is_illegal;

    assign in_execute = (state == ST_EXECUTE);
    assign ac_zero    = (ac_in == DATA_W'(0));

    opcode_decoder u_decoder (
        .opcode     (opcode),
        .ac_zero    (ac_zero),
        .in_execute (in_execute),
        .ld_ac      (ld_ac),
        .ac_src     (ac_src),
        .pc_src     (pc_src),
        .ld_pc      (ld_pc),
        .dm_we      (dm_we),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    // State, fetch wait counter, retire counter and sticky fault flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            instr_count <= count_nxt;
            illegal     <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        count_nxt   = instr_count;
        illegal_nxt = illegal;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    wait_nxt  = WAIT_LOAD;
                end
            end
            ST_FETCH: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_EXECUTE;
                end else begin
                    wait_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            ST_EXECUTE: begin
                if (is_halt) begin
                    state_nxt = ST_HALT;
                end else begin
                    if (instr_count != COUNT_MAX) begin
                        count_nxt = instr_count + COUNT_W'(1);
                    end
                    if (is_illegal) begin
                        illegal_nxt = 1'b1;
                    end
                    if (step_mode) begin
                        state_nxt = ST_PAUSE;
                    end else begin
                        state_nxt = ST_FETCH;
                        wait_nxt  = WAIT_LOAD;
                    end
                end
            end
            // A step pulse or leaving debug mode both resume fetching
            ST_PAUSE: begin
                if (step || !step_mode) begin
                    state_nxt = ST_FETCH;
                    wait_nxt  = WAIT_LOAD;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state == ST_FETCH) || (state == ST_EXECUTE) || (state == ST_PAUSE);
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomized and directed checks of control_unit_fsm against a cycle-level
// behavioural model of the fetch/execute/pause/halt sequencing.
module tb_control_unit_fsm;

    localparam int unsigned FW = 3;
    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_HALT  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic [3:0]    opcode = 4'h0;
    logic [7:0]    ac_in = 8'h00;
    logic          ld_ac;
    logic          ac_src;
    logic          pc_src;
    logic          ld_pc;
    logic          dm_we;
    logic          busy;
    logic          halted;
    logic          illegal;
    logic [CW-1:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    int m_mode = M_IDLE;
    int m_fetch_cycles = 0;
    int m_count = 0;
    bit m_illegal = 1'b0;
    int last_mode = M_IDLE;

    control_unit_fsm #(
        .FETCH_WAIT (FW),
        .COUNT_W    (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .opcode      (opcode),
        .ac_in       (ac_in),
        .ld_ac       (ld_ac),
        .ac_src      (ac_src),
        .pc_src      (pc_src),
        .ld_pc       (ld_pc),
        .dm_we       (dm_we),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    // Reference model: tracks how many cycles have been spent fetching
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode         = M_IDLE;
            m_fetch_cycles = 0;
            m_count        = 0;
            m_illegal      = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode = M_FETCH;
                    m_fetch_cycles = 1;
                end
                M_FETCH: begin
                    if (m_fetch_cycles >= int'(FW)) m_mode = M_EXEC;
                    else m_fetch_cycles++;
                end
                M_EXEC: begin
                    if (opcode == 4'hF) begin
                        m_mode = M_HALT;
                    end else begin
                        if (m_count < CNT_MAX) m_count++;
                        if (opcode >= 4'hC) m_illegal = 1'b1;
                        m_mode = step_mode ? M_PAUSE : M_FETCH;
                        m_fetch_cycles = 1;
                    end
                end
                M_PAUSE: if (step || !step_mode) begin
                    m_mode = M_FETCH;
                    m_fetch_cycles = 1;
                end
                default: ;
            endcase
        end
    end

    // Expected {ld_ac, ac_src, pc_src, ld_pc, dm_we}
    function automatic logic [4:0] exp_ctrl(input int mode, input logic [3:0] op,
                                            input logic [7:0] ac);
        logic la, asrc, ps, lp, we;
        la = 1'b0; asrc = 1'b0; ps = 1'b0; lp = 1'b0; we = 1'b0;
        if (mode == M_EXEC && op != 4'hF) begin
            lp   = 1'b1;
            la   = (op == 4'h1) || (op >= 4'h3 && op <= 4'h8);
            asrc = (op == 4'h1);
            we   = (op == 4'h2);
            ps   = (op == 4'h9) || (op == 4'hA && ac == 8'h00) || (op == 4'hB && ac != 8'h00);
        end
        return {la, asrc, ps, lp, we};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string ph);
        check_eq({ph, ":ctrl"}, 32'({ld_ac, ac_src, pc_src, ld_pc, dm_we}),
                 32'(exp_ctrl(m_mode, opcode, ac_in)));
        check_eq({ph, ":busy"}, 32'(busy),
                 32'(m_mode == M_FETCH || m_mode == M_EXEC || m_mode == M_PAUSE));
        check_eq({ph, ":halted"}, 32'(halted), 32'(m_mode == M_HALT));
        check_eq({ph, ":illegal"}, 32'(illegal), 32'(m_illegal));
        check_eq({ph, ":count"}, 32'(instr_count), 32'(m_count));
        check_eq({ph, ":ldac_dmwe"}, 32'(ld_ac & dm_we), 32'(0));
    endtask

    task automatic cycle(input logic st, input logic stp, input logic sm,
                         input logic [3:0] op, input logic [7:0] ac, input string ph);
        @(negedge clock);
        start = st; step = stp; step_mode = sm; opcode = op; ac_in = ac;
        #1;
        last_mode = m_mode;
        compare_all(ph);
    endtask

    // Holds one opcode until the model reaches EXECUTE; returns mid-cycle there
    task automatic run_until_exec(input logic st, input logic [3:0] op, input logic [7:0] ac,
                                  input logic sm, input string ph, output int n_cyc);
        bit found = 1'b0;
        n_cyc = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle((i == 0) ? st : 1'b0, 1'b0, sm, op, ac, ph);
            if (last_mode == M_EXEC) begin
                found = 1'b1;
                n_cyc = i;
            end
        end
        check_eq({ph, ":reach_exec"}, 32'(found), 32'(1));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0;
        opcode = 4'h0; ac_in = 8'h00;
        #1;
        compare_all("rst");
        @(negedge clock);
        reset = 1'b1;
        #1;
        compare_all("rst_rel");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic sm;
        logic [3:0] op;

        do_reset();
        check_eq("reset_state_idle", 32'({busy, halted, illegal, instr_count}), 32'(0));

        // Reset asserted in the middle of a LOAD execute cycle
        run_until_exec(1'b1, 4'h1, 8'h00, 1'b0, "t1", n);
        check_eq("t1_ld_ac_before", 32'(ld_ac), 32'(1));
        reset = 1'b0;
        #1;
        check_eq("t1_ctrl_async", 32'({ld_ac, ac_src, pc_src, ld_pc, dm_we}), 32'(0));
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("t1_after", 32'({busy, halted, illegal, instr_count}), 32'(0));

        // ALU op latency with FETCH_WAIT=3
        run_until_exec(1'b1, 4'h3, 8'h00, 1'b0, "t2", n);
        check_eq("t2_latency", 32'(n), 32'(4));
        check_eq("t2_exec_ctrl", 32'({ld_ac, ac_src, ld_pc}), 32'(3'b101));
        cycle(1'b0, 1'b0, 1'b0, 4'h3, 8'h00, "t2_post");
        check_eq("t2_one_cycle", 32'(ld_ac), 32'(0));
        check_eq("t2_count", 32'(instr_count), 32'(1));

        // JZ with zero and with 0x80
        run_until_exec(1'b0, 4'hA, 8'h00, 1'b0, "t3a", n);
        check_eq("t3_jz_zero", 32'({pc_src, ld_pc}), 32'(2'b11));
        run_until_exec(1'b0, 4'hA, 8'h80, 1'b0, "t3b", n);
        check_eq("t3_jz_nonzero", 32'({pc_src, ld_pc}), 32'(2'b01));

        // LOAD, STORE, HALT then ignored pulses
        do_reset();
        run_until_exec(1'b1, 4'h1, 8'h00, 1'b0, "t4_load", n);
        check_eq("t4_load_no_we", 32'(dm_we), 32'(0));
        run_until_exec(1'b0, 4'h2, 8'h00, 1'b0, "t4_store", n);
        check_eq("t4_store_we", 32'(dm_we), 32'(1));
        run_until_exec(1'b0, 4'hF, 8'h00, 1'b0, "t4_halt", n);
        for (int i = 0; i < 8; i++) cycle(i[0], i[1], 1'b0, 4'h0, 8'h00, "t4_halted");
        check_eq("t4_halted", 32'(halted), 32'(1));
        check_eq("t4_count", 32'(instr_count), 32'(2));

        // Single-step mode
        do_reset();
        run_until_exec(1'b1, 4'h0, 8'h00, 1'b1, "t5_i1", n);
        cycle(1'b0, 1'b0, 1'b1, 4'h0, 8'h00, "t5_p1");
        cycle(1'b0, 1'b1, 1'b1, 4'h0, 8'h00, "t5_s1");
        run_until_exec(1'b0, 4'h3, 8'h00, 1'b1, "t5_i2", n);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 4'h3, 8'h00, "t5_p2");
        check_eq("t5_pause_busy", 32'({busy, ld_ac, ld_pc}), 32'(3'b100));
        check_eq("t5_pause_count", 32'(instr_count), 32'(2));
        cycle(1'b0, 1'b1, 1'b1, 4'h0, 8'h00, "t5_s2");
        cycle(1'b0, 1'b1, 1'b1, 4'h0, 8'h00, "t5_fetch_step");
        run_until_exec(1'b0, 4'h0, 8'h00, 1'b1, "t5_i3", n);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 4'h0, 8'h00, "t5_p3");
        check_eq("t5_one_more", 32'(instr_count), 32'(3));
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "t5_drop_mode");
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "t5_resume");

        // Illegal opcode and counter saturation
        do_reset();
        run_until_exec(1'b1, 4'hD, 8'h00, 1'b0, "t6_ill", n);
        check_eq("t6_ill_nop", 32'({ld_ac, pc_src, ld_pc, dm_we}), 32'(4'b0010));
        for (int i = 0; i < 20; i++) run_until_exec(1'b0, 4'h0, 8'h00, 1'b0, "t6_nop", n);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, "t6_end");
        check_eq("t6_sat", 32'(instr_count), 32'(4'hF));
        check_eq("t6_sticky", 32'(illegal), 32'(1));

        // Randomized segments
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            sm = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(15) == 0) sm = ~sm;
                op = 4'($urandom_range(15));
                if (op == 4'hF && $urandom_range(3) != 0) op = 4'h0;
                cycle(($urandom_range(7) == 0), ($urandom_range(3) == 0), sm, op,
                      ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
- Multi-cycle control unit for the 8-bit accumulator CPU; sits directly upstream of the datapath.
- Consumes the opcode nibble (instruction bits [7:4]) and the accumulator value.
- Drives ld_ac, ac_src, pc_src, plus a PC load enable and a data-memory write enable.
- Sequences fetch/execute, supports single-step debug, halts on the HALT opcode and counts retired instructions.

Parameters:
- FETCH_WAIT, 1, cycles spent in FETCH for the instruction memory to settle (legal range 1..15).
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution from IDLE
- step_mode  in  1  1 = pause after every instruction
- step  in  1  one-cycle pulse; releases PAUSE
- opcode  in  4  instruction bits [7:4] from the datapath
- ac_in  in  8  accumulator value (acOut)
- ld_ac  out  1  accumulator load enable
- ac_src  out  1  0 = ALU result, 1 = data-memory data
- pc_src  out  1  0 = PC+1, 1 = instruction bits [3:0]
- ld_pc  out  1  PC load enable; datapath PC updates only when 1
- dm_we  out  1  data-memory write enable
- busy  out  1  1 in FETCH/EXECUTE/PAUSE
- halted  out  1  1 in HALT
- illegal  out  1  sticky; set by an undefined opcode
- instr_count  out  COUNT_W  retired instructions

Behaviour:
- States: IDLE, FETCH, EXECUTE, PAUSE, HALT. State register and counters are async-cleared by reset=0.
- Reset values: state=IDLE, instr_count=0, illegal=0. All control outputs, busy and halted are 0.
- Control outputs are decoded combinationally from the registered state and opcode. They are 0 in every state except EXECUTE, so they drop to 0 immediately on reset assertion.
- IDLE:
  - start=1 -> FETCH and load the wait counter with FETCH_WAIT-1.
  - Otherwise stay in IDLE.
- FETCH:
  - Wait counter decrements each cycle; at 0 -> EXECUTE.
  - Latency is exactly FETCH_WAIT cycles.
- EXECUTE lasts exactly 1 cycle. Opcode decode:
  - 0x0 NOP: ld_pc=1.
  - 0x1 LOAD: ld_ac=1, ac_src=1, ld_pc=1.
  - 0x2 STORE: dm_we=1, ld_pc=1.
  - 0x3-0x8 (ALU ops ADD, SUB, AND, OR, XOR, NOT): ld_ac=1, ac_src=0, ld_pc=1.
  - 0x9 JMP: pc_src=1, ld_pc=1.
  - 0xA JZ: ld_pc=1, pc_src=(ac_in==0).
  - 0xB JNZ: ld_pc=1, pc_src=(ac_in!=0).
  - 0xF HALT: all 0 (PC holds) -> HALT.
  - 0xC-0xE (illegal): behave as NOP and set illegal.
  - Any outputs not listed for an opcode are 0.
- EXECUTE exit (non-HALT): instr_count+1, saturating at all-ones. Next state is PAUSE if step_mode=1, else FETCH with the wait counter reloaded.
- PAUSE:
  - step=1 -> FETCH.
  - step_mode dropping to 0 while in PAUSE -> FETCH on the next edge.
- HALT: terminal; only reset leaves it. HALT is not counted.
- Ignored inputs: start outside IDLE; step outside PAUSE.
- Simultaneous start and step in IDLE: start wins, and the step is ignored.
- Reset mid-EXECUTE: outputs go to 0 asynchronously; no PC, AC or memory update on that edge.
- ac_in is sampled only in EXECUTE for JZ/JNZ. Zero test covers all 8 bits.
- Invariant: ld_ac and dm_we are never both 1.

Decomposition:
- Shared package (cpu_pkg): opcode localparams (OP_NOP..OP_HALT), state encoding, AC_SRC_ALU/AC_SRC_MEM, PC_SRC_INC/PC_SRC_JMP.
- One sub-module, opcode_decoder: purely combinational (opcode, ac_zero, in_execute) -> ld_ac, ac_src, pc_src, ld_pc, dm_we, is_halt, is_illegal.
- The FSM, wait counter and instr_count stay in control_unit_fsm.

Test Plan:
1. Assert reset=0 mid-EXECUTE of LOAD. Required: all control outputs 0 within the same cycle; state IDLE, instr_count 0, illegal 0 after release.
2. FETCH_WAIT=3, start pulse, opcode=0x3. Required: EXECUTE reached on the 4th edge after start; ld_ac=1, ac_src=0, ld_pc=1 for exactly 1 cycle; instr_count=1.
3. Opcode 0xA with ac_in=0x00, then opcode 0xA with ac_in=0x80. Required: pc_src=1 in the first case and 0 in the second; ld_pc=1 in both.
4. Sequence 0x1, 0x2, 0xF. Required: dm_we=1 only in the STORE EXECUTE; halted=1 afterwards and stays 1; instr_count=2. Later start and step pulses have no effect.
5. step_mode=1, run 2 instructions. Required: FSM rests in PAUSE with busy=1 and outputs 0; a step pulse gives exactly one more EXECUTE; a step while in FETCH is ignored.
6. Opcode 0xD, then COUNT_W=4 with 20 NOPs. Required: illegal=1 and stays set, with ld_pc=1 as for a NOP; instr_count saturates at 0xF.
